// File: rtl/flt_regfile_sb.sv
// Floating-point register file with per-entry pending (scoreboard) bits and a power-up clear sweep.
// Optional read-during-write forwarding is enabled with the FLT_REGFILE_BYPASS_EN macro.
module flt_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] flt_rd_reg1,
    output logic [DATA_W-1:0] rd_dt1,
    output logic              pend1,
    input  logic [ADDR_W-1:0] flt_rd_reg2,
    output logic [DATA_W-1:0] rd_dt2,
    output logic              pend2,
    input  logic [ADDR_W-1:0] flt_wr_reg,
    input  logic [DATA_W-1:0] wr_dt,
    input  logic              flt_reg_wr,
    input  logic [ADDR_W-1:0] rsv_reg,
    input  logic              rsv_en,
    output logic              ready
);

    // state   | meaning
    // S_CLEAR | sweeping clr_idx over the array, zeroing one entry per cycle
    // S_RUN   | normal operation, writes and reservations accepted
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic              wr_go;
    logic              rsv_go;

    // Outputs are also forced quiet while rst is held, not only after the edge.
    assign ready  = (state == S_RUN) && !rst;
    assign wr_go  = ready && flt_reg_wr;
    assign rsv_go = ready && rsv_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
        end else if (state == S_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == LAST_IDX) begin
                state <= S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (wr_go) begin
                mem[flt_wr_reg] <= wr_dt;
            end
        end
    end

    // Reservation is applied after the write-clear so a same-register collision leaves the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (wr_go) begin
                pending[flt_wr_reg] <= 1'b0;
            end
            if (rsv_go) begin
                pending[rsv_reg] <= 1'b1;
            end
        end
    end

    function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
        rd_data = '0;
        if (ready) begin
            rd_data = mem[a];
`ifdef FLT_REGFILE_BYPASS_EN
            if (flt_reg_wr && (a == flt_wr_reg)) begin
                rd_data = wr_dt;
            end
`endif
        end
    endfunction

    function automatic logic rd_pend(input logic [ADDR_W-1:0] a);
        rd_pend = 1'b0;
        if (ready) begin
            rd_pend = pending[a];
`ifdef FLT_REGFILE_BYPASS_EN
            if (flt_reg_wr && (a == flt_wr_reg)) begin
                rd_pend = rsv_en && (rsv_reg == a);
            end
`endif
        end
    endfunction

    assign rd_dt1 = rd_data(flt_rd_reg1);
    assign rd_dt2 = rd_data(flt_rd_reg2);
    assign pend1  = rd_pend(flt_rd_reg1);
    assign pend2  = rd_pend(flt_rd_reg2);

endmodule

// File: tb/tb_flt_regfile_sb.sv
// Scoreboard bench for flt_regfile_sb: directed scenarios followed by random traffic,
// checked against a cycle-count/array reference model.
module tb_flt_regfile_sb;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  flt_rd_reg1 = '0, flt_rd_reg2 = '0, flt_wr_reg = '0, rsv_reg = '0;
    logic [31:0] wr_dt = '0;
    logic        flt_reg_wr = 1'b0, rsv_en = 1'b0;
    logic [31:0] rd_dt1, rd_dt2;
    logic        pend1, pend2, ready;

    flt_regfile_sb #(.DATA_W(32), .NUM_REGS(N), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .flt_rd_reg1(flt_rd_reg1), .rd_dt1(rd_dt1), .pend1(pend1),
        .flt_rd_reg2(flt_rd_reg2), .rd_dt2(rd_dt2), .pend2(pend2),
        .flt_wr_reg(flt_wr_reg), .wr_dt(wr_dt), .flt_reg_wr(flt_reg_wr),
        .rsv_reg(rsv_reg), .rsv_en(rsv_en), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        p1;
        logic        p2;
        logic [4:0]  a1;
        logic [4:0]  a2;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model: cycles spent in the sweep, contents and reservation flags.
    bit          m_valid = 0;
    bit          m_run   = 0;
    int          m_cnt   = 0;
    logic [31:0] m_mem [N];
    bit          m_pend [N];

    function automatic logic [31:0] exp_data(input int a);
        if (!m_run || rst) return 32'h0;
`ifdef FLT_REGFILE_BYPASS_EN
        if (flt_reg_wr && a == int'(flt_wr_reg)) return wr_dt;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_pend(input int a);
        if (!m_run || rst) return 1'b0;
`ifdef FLT_REGFILE_BYPASS_EN
        if (flt_reg_wr && a == int'(flt_wr_reg)) return rsv_en && (a == int'(rsv_reg));
`endif
        return m_pend[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_valid = 1;
            m_run   = 0;
            m_cnt   = 0;
            for (int i = 0; i < N; i++) m_pend[i] = 0;
        end else if (!m_run) begin
            m_cnt++;
            if (m_cnt == N) begin
                m_run = 1;
                for (int i = 0; i < N; i++) m_mem[i] = 32'h0;
            end
        end else begin
            if (flt_reg_wr) begin
                m_mem[flt_wr_reg]  = wr_dt;
                m_pend[flt_wr_reg] = 0;
            end
            if (rsv_en) m_pend[rsv_reg] = 1;
        end
    endtask

    task automatic step(input bit r, input bit w, input int wa, input logic [31:0] wd,
                        input bit rs, input int ra, input int a1, input int a2);
        exp_t e;
        rst = r; flt_reg_wr = w; flt_wr_reg = wa[4:0]; wr_dt = wd;
        rsv_en = rs; rsv_reg = ra[4:0]; flt_rd_reg1 = a1[4:0]; flt_rd_reg2 = a2[4:0];
        #1;
        if (m_valid) begin
            e.rdy = m_run && !rst;
            e.a1 = a1[4:0]; e.a2 = a2[4:0];
            e.d1 = exp_data(a1 % N); e.d2 = exp_data(a2 % N);
            e.p1 = exp_pend(a1 % N); e.p2 = exp_pend(a2 % N);
            q.push_back(e);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int a1, input int a2);
        step(0, 0, 0, 32'h0, 0, 0, a1, a2);
    endtask

    // Monitor: sampled on the falling edge, well away from the edge that updates the DUT.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total += 5;
            if (ready !== e.rdy) begin
                bad++; $display("FAIL ready: got %0b want %0b @%0t", ready, e.rdy, $time);
            end
            if (rd_dt1 !== e.d1) begin
                bad++; $display("FAIL rd_dt1[%0d]: got %h want %h @%0t", e.a1, rd_dt1, e.d1, $time);
            end
            if (rd_dt2 !== e.d2) begin
                bad++; $display("FAIL rd_dt2[%0d]: got %h want %h @%0t", e.a2, rd_dt2, e.d2, $time);
            end
            if (pend1 !== e.p1) begin
                bad++; $display("FAIL pend1[%0d]: got %0b want %0b @%0t", e.a1, pend1, e.p1, $time);
            end
            if (pend2 !== e.p2) begin
                bad++; $display("FAIL pend2[%0d]: got %0b want %0b @%0t", e.a2, pend2, e.p2, $time);
            end
        end
    end

    initial begin
        int w;
        // Reset for one cycle, then idle: 32 not-ready cycles, ready on the 33rd.
        step(1, 0, 0, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 33; i++) idle(i, N - 1 - i);
        for (int i = 0; i < N; i++) idle(i, (i + 1) % N);

        step(0, 1, 5, 32'h3F800000, 0, 0, 0, 0);
        idle(5, 5);

        step(0, 0, 0, 32'h0, 1, 7, 7, 7);
        step(0, 1, 7, 32'h40000000, 0, 0, 7, 7);
        idle(7, 7);

        step(0, 1, 9, 32'h12345678, 1, 9, 9, 9);
        idle(9, 9);

        step(0, 1, 3, 32'hC0490FDB, 0, 0, 3, 3);
        idle(3, 3);

        // Restart the sweep at index 10; writes during CLEAR must not land.
        step(1, 0, 0, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, i, 32'hDEAD0000 + i, 1, i, i, 5);
        step(1, 1, 4, 32'hBAD0BAD0, 1, 4, 4, 4);
        for (int i = 0; i < 33; i++) step(0, 1, i % N, 32'hA5A50000 + i, 1, i % N, i % N, 9);
        for (int i = 0; i < N; i++) idle(i, (i + 7) % N);

        // Random traffic on a narrow address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 3) == 0) ? 31 : 7;
            step(($urandom_range(0, 149) == 0),
                 $urandom_range(0, 1), $urandom_range(0, w), $urandom,
                 $urandom_range(0, 1), $urandom_range(0, w),
                 $urandom_range(0, w), $urandom_range(0, w));
        end
        for (int i = 0; i < 40; i++) idle(i % N, (i + 3) % N);

        for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flt_regfile_sb.md
FLT_REGFILE_SB -- requirements
Module: flt_regfile_sb

Interface
- REQ-001 Parameter DATA_W, default 32: width of each register entry in bits.
- REQ-002 Parameter NUM_REGS, default 32: number of entries; SHALL be a power of two, at least 2.
- REQ-003 Parameter ADDR_W, default 5: address width; SHALL equal log2(NUM_REGS).
- REQ-004 Ports: one clock; reset is synchronous and active-high.
  - clk  in  1  rising-edge clock
  - rst  in  1  synchronous active-high reset
- REQ-005 Read port 1:
  - flt_rd_reg1  in  ADDR_W  read address 1
  - rd_dt1  out  DATA_W  read data 1
  - pend1  out  1  entry flt_rd_reg1 is awaiting a write
- REQ-006 Read port 2:
  - flt_rd_reg2  in  ADDR_W  read address 2
  - rd_dt2  out  DATA_W  read data 2
  - pend2  out  1  entry flt_rd_reg2 is awaiting a write
- REQ-007 Write port:
  - flt_wr_reg  in  ADDR_W  write address
  - wr_dt  in  DATA_W  write data
  - flt_reg_wr  in  1  write enable
- REQ-008 Reservation port:
  - rsv_reg  in  ADDR_W  register to reserve
  - rsv_en  in  1  mark rsv_reg pending
- REQ-009 Status: ready  out  1  high when the block accepts writes and reservations.

Function
- REQ-010 FSM has two states. CLEAR is entered on reset. RUN is entered from CLEAR once the entry at index NUM_REGS-1 has been cleared.
- REQ-011 CLEAR sequencing:
  - Each cycle, zero the entry at clr_idx and increment clr_idx (ADDR_W bits, starting at 0).
  - CLEAR lasts exactly NUM_REGS cycles after rst deasserts.
  - ready rises on the following cycle.
- REQ-012 ready SHALL be 0 in CLEAR and 1 in RUN.
- REQ-013 While ready=0:
  - flt_reg_wr and rsv_en are ignored.
  - rd_dt1 and rd_dt2 read 0.
  - pend1 and pend2 read 0.
- REQ-014 Reads are combinational from the array, with zero-cycle latency.
- REQ-015 In RUN, when flt_reg_wr=1, wr_dt is stored at flt_wr_reg on the clock edge. Write latency is one cycle.
- REQ-016 Pending bits are NUM_REGS bits wide:
  - rsv_en=1 sets pending[rsv_reg].
  - flt_reg_wr=1 clears pending[flt_wr_reg].
- REQ-017 If a write and a reservation target the same register in the same cycle, the data is written and the pending bit ends up set (the reservation wins).
- REQ-018 pend1 is pending[flt_rd_reg1] and pend2 is pending[flt_rd_reg2], both combinational.
- REQ-019 Both read ports may address the same entry; both return identical data.
- REQ-020 Addresses are used modulo NUM_REGS; no out-of-range condition exists.

Reset
- REQ-021 When rst=1 at a clock edge:
  - FSM goes to CLEAR.
  - clr_idx goes to 0.
  - All pending bits go to 0.
  - ready goes to 0.
- REQ-022 Array contents are not required to be zero until the CLEAR sweep passes each index.
- REQ-023 Asserting rst during CLEAR restarts the sweep at index 0. Asserting rst during RUN discards any same-cycle write or reservation.
- REQ-024 Output values during and immediately after reset:
  - ready=0
  - rd_dt1=rd_dt2=0
  - pend1=pend2=0

Configuration
- REQ-025 Macro FLT_REGFILE_BYPASS_EN selects read-during-write forwarding.
- REQ-026 With FLT_REGFILE_BYPASS_EN defined, in RUN:
  - A read whose address equals flt_wr_reg while flt_reg_wr=1 returns wr_dt in the same cycle.
  - The corresponding pendN reads 0, unless rsv_en targets the same register in that cycle.
- REQ-027 Without FLT_REGFILE_BYPASS_EN, reads return the pre-write array value and the current pending bit. New data is visible the cycle after the write.

Verification
- REQ-028 Reset for 1 cycle, then idle -> ready=0 for 32 cycles and 1 on cycle 33; every address reads 0.
- REQ-029 Write 32'h3F800000 to register 5 in RUN; read register 5 next cycle on both ports -> rd_dt1=rd_dt2=32'h3F800000.
- REQ-030 Reserve register 7, then next cycle write 32'h40000000 to register 7 -> pend1=1 for one cycle, then 0, data matches.
- REQ-031 Same-cycle write and reserve of register 9 -> data stored, pending[9]=1 afterwards.
- REQ-032 Write register 3 with 32'hC0490FDB while reading register 3 -> same-cycle rd_dt1=32'hC0490FDB if bypass is defined, otherwise the old value.
- REQ-033 Assert rst at sweep index 10, hold for 1 cycle -> ready low for a further 32 cycles; writes attempted during CLEAR are not stored.
